// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared constants for the ALU control pipeline: MIPS opcode/funct fields,
// EXE_*_OP ALU control encodings and the divide sequencer states.
package alu_ctrl_pipe_pkg;

  // Primary opcodes
  localparam logic [5:0] EXE_SPECIAL = 6'h00;
  localparam logic [5:0] EXE_REGIMM  = 6'h01;
  localparam logic [5:0] EXE_J       = 6'h02;
  localparam logic [5:0] EXE_JAL     = 6'h03;
  localparam logic [5:0] EXE_BEQ     = 6'h04;
  localparam logic [5:0] EXE_BNE     = 6'h05;
  localparam logic [5:0] EXE_BLEZ    = 6'h06;
  localparam logic [5:0] EXE_BGTZ    = 6'h07;
  localparam logic [5:0] EXE_ADDI    = 6'h08;
  localparam logic [5:0] EXE_ADDIU   = 6'h09;
  localparam logic [5:0] EXE_SLTI    = 6'h0A;
  localparam logic [5:0] EXE_SLTIU   = 6'h0B;
  localparam logic [5:0] EXE_ANDI    = 6'h0C;
  localparam logic [5:0] EXE_ORI     = 6'h0D;
  localparam logic [5:0] EXE_XORI    = 6'h0E;
  localparam logic [5:0] EXE_LUI     = 6'h0F;
  localparam logic [5:0] EXE_LB      = 6'h20;
  localparam logic [5:0] EXE_LH      = 6'h21;
  localparam logic [5:0] EXE_LWL     = 6'h22;
  localparam logic [5:0] EXE_LW      = 6'h23;
  localparam logic [5:0] EXE_LBU     = 6'h24;
  localparam logic [5:0] EXE_LHU     = 6'h25;
  localparam logic [5:0] EXE_LWR     = 6'h26;
  localparam logic [5:0] EXE_SB      = 6'h28;
  localparam logic [5:0] EXE_SH      = 6'h29;
  localparam logic [5:0] EXE_SWL     = 6'h2A;
  localparam logic [5:0] EXE_SW      = 6'h2B;
  localparam logic [5:0] EXE_SWR     = 6'h2E;

  // SPECIAL funct codes
  localparam logic [5:0] EXE_SLL   = 6'h00;
  localparam logic [5:0] EXE_SRL   = 6'h02;
  localparam logic [5:0] EXE_SRA   = 6'h03;
  localparam logic [5:0] EXE_SLLV  = 6'h04;
  localparam logic [5:0] EXE_SRLV  = 6'h06;
  localparam logic [5:0] EXE_SRAV  = 6'h07;
  localparam logic [5:0] EXE_JR    = 6'h08;
  localparam logic [5:0] EXE_JALR  = 6'h09;
  localparam logic [5:0] EXE_MFHI  = 6'h10;
  localparam logic [5:0] EXE_MTHI  = 6'h11;
  localparam logic [5:0] EXE_MFLO  = 6'h12;
  localparam logic [5:0] EXE_MTLO  = 6'h13;
  localparam logic [5:0] EXE_MULT  = 6'h18;
  localparam logic [5:0] EXE_MULTU = 6'h19;
  localparam logic [5:0] EXE_DIV   = 6'h1A;
  localparam logic [5:0] EXE_DIVU  = 6'h1B;
  localparam logic [5:0] EXE_ADD   = 6'h20;
  localparam logic [5:0] EXE_ADDU  = 6'h21;
  localparam logic [5:0] EXE_SUB   = 6'h22;
  localparam logic [5:0] EXE_SUBU  = 6'h23;
  localparam logic [5:0] EXE_AND   = 6'h24;
  localparam logic [5:0] EXE_OR    = 6'h25;
  localparam logic [5:0] EXE_XOR   = 6'h26;
  localparam logic [5:0] EXE_NOR   = 6'h27;
  localparam logic [5:0] EXE_SLT   = 6'h2A;
  localparam logic [5:0] EXE_SLTU  = 6'h2B;

  // ALU control encodings
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam int DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Pure combinational decode of opcode/funct into the 8-bit ALU control word.
// Mul/div/HI/LO functs are only legal when ALU_CTRL_MULDIV_EN is defined.
module alu_ctrl_dec
  import alu_ctrl_pipe_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [7:0] aluop,
  output logic       ri,
  output logic       is_div,
  output logic       div_signed
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    aluop      = EXE_ADDU_OP;
    ri         = 1'b0;
    is_div     = 1'b0;
    div_signed = 1'b0;

    case (op)
      EXE_SPECIAL: begin
        case (funct)
          EXE_ADD:  aluop = EXE_ADD_OP;
          EXE_ADDU: aluop = EXE_ADDU_OP;
          EXE_SUB:  aluop = EXE_SUB_OP;
          EXE_SUBU: aluop = EXE_SUBU_OP;
          EXE_SLT:  aluop = EXE_SLT_OP;
          EXE_SLTU: aluop = EXE_SLTU_OP;
          EXE_AND:  aluop = EXE_AND_OP;
          EXE_OR:   aluop = EXE_OR_OP;
          EXE_XOR:  aluop = EXE_XOR_OP;
          EXE_NOR:  aluop = EXE_NOR_OP;
          EXE_SLL:  aluop = EXE_SLL_OP;
          EXE_SRL:  aluop = EXE_SRL_OP;
          EXE_SRA:  aluop = EXE_SRA_OP;
          EXE_SLLV: aluop = EXE_SLLV_OP;
          EXE_SRLV: aluop = EXE_SRLV_OP;
          EXE_SRAV: aluop = EXE_SRAV_OP;
          EXE_JR, EXE_JALR: aluop = EXE_ADDU_OP;
`ifdef ALU_CTRL_MULDIV_EN
          EXE_MULT:  aluop = EXE_MULT_OP;
          EXE_MULTU: aluop = EXE_MULTU_OP;
          EXE_MFHI:  aluop = EXE_MFHI_OP;
          EXE_MFLO:  aluop = EXE_MFLO_OP;
          EXE_MTHI:  aluop = EXE_MTHI_OP;
          EXE_MTLO:  aluop = EXE_MTLO_OP;
          EXE_DIV: begin
            aluop      = EXE_DIV_OP;
            is_div     = 1'b1;
            div_signed = 1'b1;
          end
          EXE_DIVU: begin
            aluop  = EXE_DIVU_OP;
            is_div = 1'b1;
          end
`endif
          default: ri = 1'b1;
        endcase
      end
      EXE_ADDI:  aluop = EXE_ADD_OP;
      EXE_ADDIU: aluop = EXE_ADDU_OP;
      EXE_SLTI:  aluop = EXE_SLTI_OP;
      EXE_SLTIU: aluop = EXE_SLTIU_OP;
      EXE_ANDI:  aluop = EXE_ANDI_OP;
      EXE_ORI:   aluop = EXE_ORI_OP;
      EXE_XORI:  aluop = EXE_XORI_OP;
      EXE_LUI:   aluop = EXE_LUI_OP;
      // Address generation for every load and store is a signed add
      EXE_LB, EXE_LH, EXE_LWL, EXE_LW, EXE_LBU, EXE_LHU, EXE_LWR,
      EXE_SB, EXE_SH, EXE_SWL, EXE_SW, EXE_SWR: aluop = EXE_ADD_OP;
      EXE_J, EXE_JAL, EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ, EXE_REGIMM:
        aluop = EXE_ADDU_OP;
      default: ri = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// D->E ALU control register with stall/flush, plus the multi-cycle DIV/DIVU
// sequencer (present only when ALU_CTRL_MULDIV_EN is defined).
module alu_ctrl_pipe
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int ALUOP_W    = 8,
  parameter int DIV_CYCLES = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opD,
  input  logic [5:0]         functD,
  input  logic               stallE,
  input  logic               flushE,
  output logic [ALUOP_W-1:0] alucontrolE,
  output logic               riE,
  output logic               div_startE,
  output logic               div_signedE,
  output logic               div_stall,
  output logic               div_done
);

  localparam logic [ALUOP_W-1:0] BUBBLE_OP = ALUOP_W'(EXE_ADDU_OP);

  logic [7:0] dec_aluop;
  logic       dec_ri;
  logic       dec_is_div;
  logic       dec_div_signed;
  logic       load;

  alu_ctrl_dec u_dec (
    .op         (opD),
    .funct      (functD),
    .aluop      (dec_aluop),
    .ri         (dec_ri),
    .is_div     (dec_is_div),
    .div_signed (dec_div_signed)
  );

`ifdef ALU_CTRL_MULDIV_EN
  localparam logic [DIV_CNT_W-1:0] CNT_INIT = DIV_CNT_W'(DIV_CYCLES - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 start;

  assign div_stall = (state_q == DIV_BUSY);
  assign div_done  = (state_q == DIV_DONE);
  // flushE outranks every hold, so a flushed cycle never loads
  assign load      = !flushE && !(stallE || div_stall);
  assign start     = load && dec_is_div;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      DIV_BUSY: begin
        if (flushE) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DIV_CNT_W'(1)) begin
          state_d = DIV_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DIV_CNT_W'(1);
        end
      end
      DIV_DONE: begin
        if (flushE) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (!stallE) begin
          // Result consumed; a following divide chains straight into BUSY
          if (start) begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = DIV_IDLE;
          end
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_startE  <= 1'b0;
      div_signedE <= 1'b0;
    end else begin
      div_startE <= start;
      if (flushE) begin
        div_signedE <= 1'b0;
      end else if (load) begin
        div_signedE <= dec_div_signed;
      end
    end
  end
`else
  logic unused_div;

  assign load        = !flushE && !stallE;
  assign div_startE  = 1'b0;
  assign div_signedE = 1'b0;
  assign div_stall   = 1'b0;
  assign div_done    = 1'b0;
  assign unused_div  = dec_is_div ^ dec_div_signed ^ DIV_CYCLES[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alucontrolE <= BUBBLE_OP;
      riE         <= 1'b0;
    end else if (flushE) begin
      alucontrolE <= BUBBLE_OP;
      riE         <= 1'b0;
    end else if (load) begin
      alucontrolE <= ALUOP_W'(dec_aluop);
      riE         <= dec_ri;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed reset/stream/divide steps
// followed by a randomized stream compared against a table-driven model.
module tb_alu_ctrl_pipe;
  import alu_ctrl_pipe_pkg::*;

  localparam int ALUOP_W    = 8;
  localparam int DIV_CYCLES = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [5:0]         opD;
  logic [5:0]         functD;
  logic               stallE;
  logic               flushE;
  logic [ALUOP_W-1:0] alucontrolE;
  logic               riE;
  logic               div_startE;
  logic               div_signedE;
  logic               div_stall;
  logic               div_done;

  int passes = 0;
  int fails  = 0;

  logic [7:0] r_op [64];
  bit         r_ok [64];
  logic [7:0] i_op [64];
  bit         i_ok [64];

  always #5 clk = ~clk;

  alu_ctrl_pipe #(
    .ALUOP_W    (ALUOP_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opD         (opD),
    .functD      (functD),
    .stallE      (stallE),
    .flushE      (flushE),
    .alucontrolE (alucontrolE),
    .riE         (riE),
    .div_startE  (div_startE),
    .div_signedE (div_signedE),
    .div_stall   (div_stall),
    .div_done    (div_done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    if (obs === exp) passes++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    if (obs === exp) passes++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic [5:0] op, input logic [5:0] f);
    opD    = op;
    functD = f;
  endtask

  task automatic init_tables;
    for (int i = 0; i < 64; i++) begin
      r_ok[i] = 1'b0; r_op[i] = 8'h00;
      i_ok[i] = 1'b0; i_op[i] = 8'h00;
    end
    r_op[6'h20] = EXE_ADD_OP;  r_op[6'h21] = EXE_ADDU_OP;
    r_op[6'h22] = EXE_SUB_OP;  r_op[6'h23] = EXE_SUBU_OP;
    r_op[6'h2A] = EXE_SLT_OP;  r_op[6'h2B] = EXE_SLTU_OP;
    r_op[6'h24] = EXE_AND_OP;  r_op[6'h25] = EXE_OR_OP;
    r_op[6'h26] = EXE_XOR_OP;  r_op[6'h27] = EXE_NOR_OP;
    r_op[6'h00] = EXE_SLL_OP;  r_op[6'h02] = EXE_SRL_OP;
    r_op[6'h03] = EXE_SRA_OP;  r_op[6'h04] = EXE_SLLV_OP;
    r_op[6'h06] = EXE_SRLV_OP; r_op[6'h07] = EXE_SRAV_OP;
    r_op[6'h08] = EXE_ADDU_OP; r_op[6'h09] = EXE_ADDU_OP;
    foreach (r_ok[i]) r_ok[i] = (r_op[i] != 8'h00);
`ifdef ALU_CTRL_MULDIV_EN
    r_op[6'h18] = EXE_MULT_OP; r_op[6'h19] = EXE_MULTU_OP;
    r_op[6'h1A] = EXE_DIV_OP;  r_op[6'h1B] = EXE_DIVU_OP;
    r_op[6'h10] = EXE_MFHI_OP; r_op[6'h11] = EXE_MTHI_OP;
    r_op[6'h12] = EXE_MFLO_OP; r_op[6'h13] = EXE_MTLO_OP;
    foreach (r_ok[i]) r_ok[i] = (r_op[i] != 8'h00);
`endif
    i_op[6'h08] = EXE_ADD_OP;   i_op[6'h09] = EXE_ADDU_OP;
    i_op[6'h0A] = EXE_SLTI_OP;  i_op[6'h0B] = EXE_SLTIU_OP;
    i_op[6'h0C] = EXE_ANDI_OP;  i_op[6'h0D] = EXE_ORI_OP;
    i_op[6'h0E] = EXE_XORI_OP;  i_op[6'h0F] = EXE_LUI_OP;
    for (int i = 6'h20; i <= 6'h26; i++) i_op[i] = EXE_ADD_OP;
    for (int i = 6'h28; i <= 6'h2B; i++) i_op[i] = EXE_ADD_OP;
    i_op[6'h2E] = EXE_ADD_OP;
    for (int i = 1; i <= 7; i++) i_op[i] = EXE_ADDU_OP;
    foreach (i_ok[i]) i_ok[i] = (i_op[i] != 8'h00);
  endtask

  function automatic void model_dec(input logic [5:0] op, input logic [5:0] f,
                                    output logic [7:0] a, output logic ri);
    bit ok;
    ok = (op == 6'h00) ? r_ok[f] : i_ok[op];
    a  = !ok ? EXE_ADDU_OP : ((op == 6'h00) ? r_op[f] : i_op[op]);
    ri = !ok;
  endfunction

  // Called in the first cycle a divide sits in E; walks it to its DONE cycle.
  task automatic div_run(input string tag, input bit sgn);
    for (int k = 0; k < DIV_CYCLES; k++) begin
      if (k > 0) tick;
      chk1($sformatf("%s_start_c%0d", tag, k), div_startE, k == 0);
      chk1($sformatf("%s_stall_c%0d", tag, k), div_stall, k < DIV_CYCLES - 1);
      chk1($sformatf("%s_done_c%0d", tag, k), div_done, k == DIV_CYCLES - 1);
      chk1($sformatf("%s_signed_c%0d", tag, k), div_signedE, sgn);
      chk8($sformatf("%s_alu_c%0d", tag, k), alucontrolE, sgn ? EXE_DIV_OP : EXE_DIVU_OP);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_a, nxt_a;
    logic       exp_ri, nxt_ri;
    logic [5:0] op, f;

    init_tables();
    rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
    setd(6'h23, 6'h00);

    // Reset
    tick; tick;
    chk8("rst_alu", alucontrolE, EXE_ADDU_OP);
    chk1("rst_ri", riE, 1'b0);
    chk1("rst_start", div_startE, 1'b0);
    chk1("rst_signed", div_signedE, 1'b0);
    chk1("rst_stall", div_stall, 1'b0);
    chk1("rst_done", div_done, 1'b0);
    rst = 1'b0;
    tick;
    chk8("lw_alu", alucontrolE, EXE_ADD_OP);

    // Stream
    setd(6'h00, 6'h20); tick;
    chk8("add_alu", alucontrolE, EXE_ADD_OP);  chk1("add_ri", riE, 1'b0);
    setd(6'h0D, 6'h00); tick;
    chk8("ori_alu", alucontrolE, EXE_ORI_OP);
    setd(6'h00, 6'h2B); tick;
    chk8("sltu_alu", alucontrolE, EXE_SLTU_OP);
    setd(6'h3F, 6'h00); tick;
    chk8("rsvd_alu", alucontrolE, EXE_ADDU_OP); chk1("rsvd_ri", riE, 1'b1);

    // External stall freezes E
    setd(6'h0D, 6'h00); tick;
    setd(6'h00, 6'h2B); stallE = 1'b1;
    tick; chk8("stall1_alu", alucontrolE, EXE_ORI_OP);
    tick; chk8("stall2_alu", alucontrolE, EXE_ORI_OP);
    stallE = 1'b0;
    tick; chk8("unstall_alu", alucontrolE, EXE_SLTU_OP);

    // Flush bubbles E
    setd(6'h00, 6'h24); flushE = 1'b1;
    tick; chk8("flush_alu", alucontrolE, EXE_ADDU_OP); chk1("flush_ri", riE, 1'b0);
    flushE = 1'b0;

`ifdef ALU_CTRL_MULDIV_EN
    // Single DIV
    setd(6'h00, 6'h1A); tick;
    setd(6'h00, 6'h20);
    div_run("div", 1'b1);
    tick;
    chk8("div_next_alu", alucontrolE, EXE_ADD_OP);
    chk1("div_next_done", div_done, 1'b0);
    chk1("div_next_stall", div_stall, 1'b0);

    // Back-to-back DIVU then DIV
    setd(6'h00, 6'h1B); tick;
    setd(6'h00, 6'h1A);
    div_run("divu_b2b", 1'b0);
    tick;
    setd(6'h00, 6'h20);
    div_run("div_b2b", 1'b1);
    tick;
    chk8("b2b_next_alu", alucontrolE, EXE_ADD_OP);
    chk1("b2b_next_start", div_startE, 1'b0);

    // Flush in BUSY aborts the divide
    setd(6'h00, 6'h1A); tick;
    setd(6'h00, 6'h20);
    chk1("fl_start", div_startE, 1'b1);
    tick; flushE = 1'b1;
    tick; flushE = 1'b0;
    chk8("fl_alu", alucontrolE, EXE_ADDU_OP);
    chk1("fl_stall", div_stall, 1'b0);
    chk1("fl_done", div_done, 1'b0);
    chk1("fl_start2", div_startE, 1'b0);
    chk1("fl_signed", div_signedE, 1'b0);
    tick;
    chk8("fl_next_alu", alucontrolE, EXE_ADD_OP);
    for (int i = 0; i < DIV_CYCLES; i++) begin
      chk1($sformatf("fl_after_done_%0d", i), div_done, 1'b0);
      chk1($sformatf("fl_after_stall_%0d", i), div_stall, 1'b0);
      tick;
    end

    // External stall while in DONE
    setd(6'h00, 6'h1A); tick;
    setd(6'h00, 6'h25);
    for (int k = 1; k < DIV_CYCLES; k++) tick;
    stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("dstall_done_%0d", i), div_done, 1'b1);
      chk1($sformatf("dstall_stall_%0d", i), div_stall, 1'b0);
      chk8($sformatf("dstall_alu_%0d", i), alucontrolE, EXE_DIV_OP);
      tick;
    end
    stallE = 1'b0;
    chk8("dstall_held_alu", alucontrolE, EXE_DIV_OP);
    tick;
    chk8("dstall_next_alu", alucontrolE, EXE_OR_OP);
    chk1("dstall_next_done", div_done, 1'b0);

    // Reset in the middle of a divide
    setd(6'h00, 6'h1A); tick;
    setd(6'h00, 6'h20); tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk8("mrst_alu", alucontrolE, EXE_ADDU_OP);
    chk1("mrst_start", div_startE, 1'b0);
    chk1("mrst_signed", div_signedE, 1'b0);
    chk1("mrst_stall", div_stall, 1'b0);
    chk1("mrst_done", div_done, 1'b0);
    tick;
    chk8("mrst_next_alu", alucontrolE, EXE_ADD_OP);
    chk1("mrst_next_stall", div_stall, 1'b0);
`else
    // Mul/div functs are reserved without the feature
    setd(6'h00, 6'h18); tick;
    chk8("mult_alu", alucontrolE, EXE_ADDU_OP);
    chk1("mult_ri", riE, 1'b1);
    setd(6'h00, 6'h1A); tick;
    chk1("div_ri", riE, 1'b1);
    chk1("div_stall_off", div_stall, 1'b0);
    chk1("div_start_off", div_startE, 1'b0);
    tick;
    chk1("div_done_off", div_done, 1'b0);
`endif

    // Randomized stream (no divides) with random stall/flush
    setd(6'h00, 6'h20); stallE = 1'b0; flushE = 1'b0;
    tick;
    exp_a = EXE_ADD_OP; exp_ri = 1'b0;
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom_range(0, 63));
      f  = 6'($urandom_range(0, 63));
`ifdef ALU_CTRL_MULDIV_EN
      if (op == 6'h00 && (f == 6'h1A || f == 6'h1B)) f = 6'h21;
`endif
      setd(op, f);
      stallE = ($urandom_range(0, 4) == 0);
      flushE = ($urandom_range(0, 9) == 0);
      model_dec(op, f, nxt_a, nxt_ri);
      if (flushE) begin
        exp_a = EXE_ADDU_OP; exp_ri = 1'b0;
      end else if (!stallE) begin
        exp_a = nxt_a; exp_ri = nxt_ri;
      end
      tick;
      chk8($sformatf("rnd_alu_%0d", n), alucontrolE, exp_a);
      chk1($sformatf("rnd_ri_%0d", n), riE, exp_ri);
      chk1($sformatf("rnd_stall_%0d", n), div_stall, 1'b0);
    end
    stallE = 1'b0; flushE = 1'b0;

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
